// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the FSM state encoding and the PC mux select codes.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SEQ   = 2'b00;
    localparam logic [1:0] SEL_REDIR = 2'b01;
    localparam logic [1:0] SEL_RST   = 2'b10;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts instruction-memory wait cycles and flags the cycle on which the
// MAX_WAIT-th consecutive not-ready wait cycle occurs.
module fetch_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != W'(MAX_WAIT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the wait cycle that would bring the count up to MAX_WAIT.
    assign expire = inc && (cnt_q == W'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences PC updates, IF/ID control, redirects,
// load-use stalls and instruction-memory wait/timeout handling.
//
// state   | meaning
// S_RESET | one cycle loading the reset vector, flushing IF/ID
// S_FETCH | request outstanding, first cycle of a fetch
// S_WAIT  | memory not ready yet, PC frozen, timeout counting
// S_ERROR | memory timed out; sticky until RST
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EX_MEM_PCSrc,
    input  logic [31:0]      EX_MEM_NPC,
    input  logic             hazard_stall,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [1:0]       pc_sel,
    output logic [31:0]      pc_target,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             imem_err,
    output logic [CNT_W-1:0] fetch_count
);

    state_t           state_q, state_d;
    logic             pend_q;
    logic [31:0]      tgt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic busy, complete, redir, cnt_inc;
    logic timer_clear, timer_inc, expire;

    assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT);
    assign complete    = busy && imem_ready;
    assign redir       = EX_MEM_PCSrc || pend_q;
    assign timer_clear = (state_q == S_FETCH) && !imem_ready;
    assign timer_inc   = (state_q == S_WAIT) && !imem_ready;

    fetch_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_timer (
        .CLK   (CLK),
        .RST   (RST),
        .clear (timer_clear),
        .inc   (timer_inc),
        .expire(expire)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RESET;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // A live target always overwrites the held one; completion consumes it.
            if (complete) begin
                pend_q <= 1'b0;
            end else if (EX_MEM_PCSrc && (state_q != S_ERROR)) begin
                pend_q <= 1'b1;
                tgt_q  <= EX_MEM_NPC;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_d == S_ERROR) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        pc_sel      = SEL_SEQ;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        cnt_inc     = 1'b0;

        case (state_q)
            S_RESET: begin
                pc_sel      = SEL_RST;
                pc_write    = 1'b1;
                if_id_flush = 1'b1;
                state_d     = S_FETCH;
            end
            S_FETCH, S_WAIT: begin
                imem_req = 1'b1;
                if (complete) begin
                    state_d = S_FETCH;
                    if (redir) begin
                        pc_sel      = SEL_REDIR;
                        pc_write    = 1'b1;
                        if_id_flush = 1'b1;
                    end else if (!hazard_stall) begin
                        pc_sel      = SEL_SEQ;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        cnt_inc     = 1'b1;
                    end
                end else if (state_q == S_FETCH) begin
                    state_d = S_WAIT;
                end else if (expire) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        if (RST) begin
            imem_req    = 1'b0;
            pc_sel      = SEL_SEQ;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b0;
            cnt_inc     = 1'b0;
        end
    end

    assign pc_target   = RST ? 32'd0 : (EX_MEM_PCSrc ? EX_MEM_NPC : tgt_q);
    assign imem_err    = err_q && !RST;
    assign fetch_count = RST ? '0 : cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with hand-computed expectations; runs with a
// short timeout and a 4-bit fetch counter so wrap and error paths are reachable.
module tb_fetch_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;

    // {imem_req, pc_sel[1:0], pc_write, if_id_write, if_id_flush}
    localparam logic [5:0] CTL_IDLE  = 6'b0_00_0_0_0;
    localparam logic [5:0] CTL_RST   = 6'b0_10_1_0_1;
    localparam logic [5:0] CTL_SEQ   = 6'b1_00_1_1_0;
    localparam logic [5:0] CTL_WAIT  = 6'b1_00_0_0_0;
    localparam logic [5:0] CTL_REDIR = 6'b1_01_1_0_1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EX_MEM_PCSrc = 1'b0;
    logic [31:0]      EX_MEM_NPC = 32'd0;
    logic             hazard_stall = 1'b0;
    logic             imem_ready = 1'b0;
    logic             imem_req;
    logic [1:0]       pc_sel;
    logic [31:0]      pc_target;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             imem_err;
    logic [CNT_W-1:0] fetch_count;
    logic [5:0]       ctl;

    int n_vec = 0;
    int n_bad = 0;

    fetch_ctrl #(
        .MAX_WAIT(MAX_WAIT),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EX_MEM_PCSrc(EX_MEM_PCSrc),
        .EX_MEM_NPC  (EX_MEM_NPC),
        .hazard_stall(hazard_stall),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .pc_sel      (pc_sel),
        .pc_target   (pc_target),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .imem_err    (imem_err),
        .fetch_count (fetch_count)
    );

    always #5 CLK = ~CLK;

    assign ctl = {imem_req, pc_sel, pc_write, if_id_write, if_id_flush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs shortly after a rising edge and let combinational outputs settle.
    task automatic cyc(input logic rst, input logic pcsrc, input logic [31:0] npc,
                       input logic stall, input logic ready);
        RST          = rst;
        EX_MEM_PCSrc = pcsrc;
        EX_MEM_NPC   = npc;
        hazard_stall = stall;
        imem_ready   = ready;
        #1;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset holds every output low
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_ctl", 32'(ctl), 32'(CTL_IDLE));
        chk("rst_err", 32'(imem_err), 32'd0);
        chk("rst_cnt", 32'(fetch_count), 32'd0);
        tick;

        // Reset vector then four sequential fetches
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("reset_state_ctl", 32'(ctl), 32'(CTL_RST));
        tick;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            chk("seq_ctl", 32'(ctl), 32'(CTL_SEQ));
            tick;
        end
        chk("seq_cnt4", 32'(fetch_count), 32'd4);

        // Wait with redirect arriving mid-wait
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("wait1_ctl", 32'(ctl), 32'(CTL_WAIT));
        tick;
        cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        chk("wait2_ctl", 32'(ctl), 32'(CTL_WAIT));
        tick;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("wait3_ctl", 32'(ctl), 32'(CTL_WAIT));
        tick;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("pend_redir_ctl", 32'(ctl), 32'(CTL_REDIR));
        chk("pend_redir_tgt", pc_target, 32'h40);
        tick;
        chk("pend_redir_cnt", 32'(fetch_count), 32'd4);

        // Load-use stall for two completions, then release
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            chk("stall_ctl", 32'(ctl), 32'(CTL_WAIT));
            tick;
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("unstall_ctl", 32'(ctl), 32'(CTL_SEQ));
        tick;
        chk("unstall_cnt", 32'(fetch_count), 32'd5);

        // Redirect overrides a simultaneous stall
        cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        chk("redir_stall_ctl", 32'(ctl), 32'(CTL_REDIR));
        chk("redir_stall_tgt", pc_target, 32'h100);
        tick;
        chk("redir_stall_cnt", 32'(fetch_count), 32'd5);

        // Timeout: one fetch cycle then four not-ready wait cycles
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("to_fetch_ctl", 32'(ctl), 32'(CTL_WAIT));
        tick;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            chk("to_wait_ctl", 32'(ctl), 32'(CTL_WAIT));
            chk("to_wait_err", 32'(imem_err), 32'd0);
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            chk("err_ctl", 32'(ctl), 32'(CTL_IDLE));
            chk("err_flag", 32'(imem_err), 32'd1);
            tick;
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("err_rst_flag", 32'(imem_err), 32'd0);
        chk("err_rst_ctl", 32'(ctl), 32'(CTL_IDLE));
        tick;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("err_rst_state", 32'(ctl), 32'(CTL_RST));
        chk("err_rst_cnt", 32'(fetch_count), 32'd0);
        tick;

        // Pending redirect does not survive reset
        cyc(1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
        chk("kill_wait_ctl", 32'(ctl), 32'(CTL_WAIT));
        tick;
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("kill_rst_tgt", pc_target, 32'h0);
        tick;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("kill_reset_ctl", 32'(ctl), 32'(CTL_RST));
        tick;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("kill_seq_ctl", 32'(ctl), 32'(CTL_SEQ));
        chk("kill_seq_tgt", pc_target, 32'h0);
        tick;
        chk("kill_cnt1", 32'(fetch_count), 32'd1);

        // Counter wrap at 2^CNT_W
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            tick;
        end
        chk("wrap_pre", 32'(fetch_count), 32'd15);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_ctl", 32'(ctl), 32'(CTL_SEQ));
        tick;
        chk("wrap_cnt0", 32'(fetch_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The module SHALL have parameter MAX_WAIT, default 15: maximum instruction-memory wait cycles before error.
REQ-002 The module SHALL have parameter CNT_W, default 32: width of the fetch counter.
REQ-003 The module SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port RST, input, 1; RST is synchronous and active-high.
REQ-005 The module SHALL have port EX_MEM_PCSrc, input, 1: branch/jump redirect request from EX/MEM.
REQ-006 The module SHALL have port EX_MEM_NPC, input, 32: redirect target.
REQ-007 The module SHALL have port hazard_stall, input, 1: load-use stall request from decode.
REQ-008 The module SHALL have port imem_ready, input, 1: instruction for the current PC is valid this cycle.
REQ-009 The module SHALL have port imem_req, output, 1: fetch request to instruction memory.
REQ-010 The module SHALL have port pc_sel, output, 2: PC mux select; 00 = sequential, 01 = redirect, 10 = reset vector.
REQ-011 The module SHALL have port pc_target, output, 32: redirect target presented to the PC mux.
REQ-012 The module SHALL have ports pc_write, if_id_write and if_id_flush, each output, 1: PC and IF/ID register controls.
REQ-013 The module SHALL have ports imem_err, output, 1 (sticky timeout flag) and fetch_count, output, CNT_W (completed fetches).

Function
REQ-014 The FSM SHALL have states S_RESET, S_FETCH, S_WAIT and S_ERROR.
REQ-015 S_RESET SHALL last one cycle with pc_sel=10, pc_write=1, if_id_flush=1 and imem_req=0, then go to S_FETCH.
REQ-016 S_FETCH and S_WAIT SHALL drive imem_req=1; a completion is imem_ready=1 in either state.
REQ-017 In S_FETCH with imem_ready=0 the FSM SHALL go to S_WAIT with PC frozen (pc_write=0) until completion.
REQ-018 On completion with a live or pending redirect: pc_sel=01, pc_write=1, if_id_write=0, if_id_flush=1, clear pending, go to S_FETCH.
REQ-019 Redirect priority: a live EX_MEM_PCSrc target SHALL win over a latched one, and a redirect SHALL override hazard_stall.
REQ-020 On completion with hazard_stall=1 and no redirect: pc_write=0, if_id_write=0, no flush, go to S_FETCH to refetch the same PC.
REQ-021 On completion otherwise: pc_sel=00, pc_write=1, if_id_write=1, increment fetch_count, go to S_FETCH.
REQ-022 fetch_count SHALL wrap modulo 2^CNT_W.
REQ-023 EX_MEM_PCSrc=1 without completion SHALL latch EX_MEM_NPC and set pending; a later redirect overwrites the latched target.
REQ-024 pc_target SHALL equal EX_MEM_NPC when EX_MEM_PCSrc=1, else the latched target.
REQ-025 The wait counter SHALL clear on entry to S_WAIT and increment each S_WAIT cycle without imem_ready.
REQ-026 When the wait counter reaches MAX_WAIT without imem_ready, the FSM SHALL go to S_ERROR.
REQ-027 S_ERROR SHALL set imem_err=1 and drive all control outputs 0; only RST leaves it.
REQ-028 Outputs not stated for a cycle SHALL be 0.

Reset
REQ-029 While RST=1 the module SHALL drive every output 0 and clear state, wait counter, pending flag, latched target, fetch_count and imem_err; the FSM goes to S_RESET.
REQ-030 RST asserted mid-wait or mid-redirect SHALL abandon all work, with no redirect surviving reset.

Structure
REQ-031 Package fetch_ctrl_pkg SHALL hold the state encoding and the pc_sel constants SEL_SEQ, SEL_REDIR and SEL_RST.
REQ-032 The wait counter and timeout compare SHALL be one sub-module, fetch_wait_timer; all else is flat.

Verification
REQ-033 Reset then imem_ready held at 1 for 5 cycles -> one S_RESET cycle with pc_sel=10, then 4 sequential completions with fetch_count=4.
REQ-034 imem_ready low 3 cycles, and EX_MEM_PCSrc=1 with NPC=0x40 in wait cycle 2 -> at completion pc_sel=01, pc_target=0x40, if_id_flush=1, fetch_count unchanged.
REQ-035 hazard_stall=1 with imem_ready=1 for 2 cycles -> pc_write=0 and if_id_write=0 both cycles; third cycle without stall -> pc_write=1.
REQ-036 Simultaneous hazard_stall=1, EX_MEM_PCSrc=1 (NPC=0x100) and imem_ready=1 -> redirect taken with pc_sel=01 and if_id_flush=1.
REQ-037 imem_ready held 0 with MAX_WAIT=4 -> S_ERROR after 4 wait cycles with imem_err=1 sticky; RST -> imem_err=0, then S_RESET.
REQ-038 Preload fetch_count=2^CNT_W-1, then one normal completion -> fetch_count=0.
